ecc_dec_pipe: RTL and testbench

// Extended-Hamming (SECDED) decoder; receive-side counterpart of the ENC_STAGE_1 encoder path.
// - Accepts a padded codeword in one of three modes and computes the syndrome against the shared H matrices.
// - Corrects a single-bit error, flags a double-bit error, and returns the info bits.
// - 2-stage valid/ready pipeline sitting between the channel model and the result checker.

---
 rtl/ecc_pkg.sv | 73 +++++++
 rtl/ecc_syndrome_calc.sv | 22 ++
 rtl/ecc_dec_pipe.sv | 111 +++++++++++
 tb/tb_ecc_dec_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: mode and error encodings, per-mode widths and the
// H matrices used by both the encoder and this decoder.
package ecc_pkg;
    localparam int MAX_CODEWORD_WIDTH = 32;
    localparam int MAX_INFO_WIDTH     = 26;
    localparam int MAX_PARITY_WIDTH   = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

    typedef enum logic [1:0] {
        MOD_8_4     = 2'b00,
        MOD_16_11   = 2'b01,
        MOD_32_26   = 2'b10,
        MOD_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ERR_NONE          = 2'b00,
        ERR_CORRECTED     = 2'b01,
        ERR_UNCORRECTABLE = 2'b10,
        ERR_ILLEGAL_MODE  = 2'b11
    } err_e;

    typedef logic [MAX_PARITY_WIDTH-1:0][MAX_CODEWORD_WIDTH-1:0] h_matrix_t;

    // Row r masks the codeword bits checked by syndrome bit r; the top used row is overall parity.
    // Info bit i owns the i-th smallest check pattern of weight >= 2, so every column is distinct.
    localparam h_matrix_t H_MATRIX_1 = {32'h0000_0000, 32'h0000_0000, 32'h0000_00FF,
                                        32'h0000_00E4, 32'h0000_00D2, 32'h0000_00B1};
    localparam h_matrix_t H_MATRIX_2 = {32'h0000_0000, 32'h0000_FFFF, 32'h0000_FE08,
                                        32'h0000_F1C4, 32'h0000_CDA2, 32'h0000_AB61};
    localparam h_matrix_t H_MATRIX_3 = {32'hFFFF_FFFF, 32'hFFFE_0010, 32'hFF01_FC08,
                                        32'hF0F1_E384, 32'hCCCD_9B42, 32'hAAAB_56C1};

    function automatic h_matrix_t h_matrix_sel(input mode_e mode);
        h_matrix_t h;
        case (mode)
            MOD_8_4:   h = H_MATRIX_1;
            MOD_16_11: h = H_MATRIX_2;
            MOD_32_26: h = H_MATRIX_3;
            default:   h = '0;
        endcase
        return h;
    endfunction

    function automatic logic [2:0] parity_width(input mode_e mode);
        logic [2:0] p;
        case (mode)
            MOD_8_4:   p = 3'd4;
            MOD_16_11: p = 3'd5;
            MOD_32_26: p = 3'd6;
            default:   p = 3'd0;
        endcase
        return p;
    endfunction

    function automatic logic [MAX_CODEWORD_WIDTH-1:0] codeword_mask(input mode_e mode);
        logic [MAX_CODEWORD_WIDTH-1:0] m;
        case (mode)
            MOD_8_4:   m = 32'h0000_00FF;
            MOD_16_11: m = 32'h0000_FFFF;
            MOD_32_26: m = 32'hFFFF_FFFF;
            default:   m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    function automatic logic [MAX_PARITY_WIDTH-1:0] h_column(input h_matrix_t h, input int col);
        logic [MAX_PARITY_WIDTH-1:0] c;
        for (int r = 0; r < MAX_PARITY_WIDTH; r++) begin
            c[r] = h[r][col];
        end
        return c;
    endfunction
endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational syndrome of a masked codeword against the H matrix of its mode;
// unused upper syndrome bits come out zero because those H rows are zero.
module ecc_syndrome_calc
    import ecc_pkg::*;
(
    input  logic [MAX_CODEWORD_WIDTH-1:0] codeword,
    input  mode_e                         mod,
    output logic [MAX_PARITY_WIDTH-1:0]   syndrome
);

    h_matrix_t h_s;

    // One parity check per H row.
    always_comb begin
        h_s      = h_matrix_sel(mod);
        syndrome = '0;
        for (int r = 0; r < MAX_PARITY_WIDTH; r++) begin
            syndrome[r] = ^(codeword & h_s[r]);
        end
    end

endmodule

// File: rtl/ecc_dec_pipe.sv
// Two-stage SECDED decoder: stage 1 registers codeword and syndrome, stage 2
// registers the corrected info bits and error classification.
module ecc_dec_pipe
    import ecc_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    mod,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors,
    output logic                          out_valid,
    input  logic                          out_ready
);

    logic                          en_s;
    mode_e                         in_mod_s;
    logic [MAX_CODEWORD_WIDTH-1:0] in_cw_s;
    logic [MAX_PARITY_WIDTH-1:0]   in_syn_s;

    logic                          s1_valid_r;
    logic [MAX_CODEWORD_WIDTH-1:0] s1_cw_r;
    mode_e                         s1_mod_r;
    logic [MAX_PARITY_WIDTH-1:0]   s1_syn_r;

    h_matrix_t                     h2_s;
    logic [2:0]                    pw_s;
    logic                          top_s;
    logic [MAX_CODEWORD_WIDTH-1:0] match_s;
    logic [MAX_CODEWORD_WIDTH-1:0] corr_s;
    err_e                          err_s;
    logic [MAX_INFO_WIDTH-1:0]     data_s;

    // Whole pipe advances together whenever the output slot is free or being drained.
    assign en_s     = out_ready || !out_valid;
    assign in_ready = en_s;
    assign in_mod_s = mode_e'(mod);
    assign in_cw_s  = data_in & codeword_mask(in_mod_s);

    ecc_syndrome_calc u_syndrome (
        .codeword (in_cw_s),
        .mod      (in_mod_s),
        .syndrome (in_syn_s)
    );

    // Stage 1: capture the codeword, its mode and syndrome.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_cw_r    <= '0;
            s1_mod_r   <= MOD_8_4;
            s1_syn_r   <= '0;
        end else if (en_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_cw_r  <= in_cw_s;
                s1_mod_r <= in_mod_s;
                s1_syn_r <= in_syn_s;
            end
        end
    end

    // Stage 2 logic: classify the syndrome, flip the matching column, strip parity.
    always_comb begin
        h2_s    = h_matrix_sel(s1_mod_r);
        pw_s    = parity_width(s1_mod_r);
        match_s = '0;
        for (int j = 0; j < MAX_CODEWORD_WIDTH; j++) begin
            match_s[j] = (h_column(h2_s, j) == s1_syn_r);
        end
        case (s1_mod_r)
            MOD_8_4:   top_s = s1_syn_r[3];
            MOD_16_11: top_s = s1_syn_r[4];
            MOD_32_26: top_s = s1_syn_r[5];
            default:   top_s = 1'b0;
        endcase
        // Columns beyond n are zero, so only in-range bits can match a nonzero syndrome.
        if (s1_mod_r == MOD_ILLEGAL) begin
            err_s  = ERR_ILLEGAL_MODE;
            corr_s = '0;
        end else if (s1_syn_r == '0) begin
            err_s  = ERR_NONE;
            corr_s = s1_cw_r;
        end else if (top_s && (match_s != '0)) begin
            err_s  = ERR_CORRECTED;
            corr_s = s1_cw_r ^ match_s;
        end else begin
            err_s  = ERR_UNCORRECTABLE;
            corr_s = s1_cw_r;
        end
        data_s = MAX_INFO_WIDTH'(corr_s >> pw_s);
    end

    // Stage 2 registers: the externally visible result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            data_out      <= '0;
            num_of_errors <= 2'b00;
        end else if (en_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                data_out      <= data_s;
                num_of_errors <= err_s;
            end
        end
    end

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// Bench for ecc_dec_pipe: a nearest-codeword reference model feeds an in-order
// scoreboard that is compared with the DUT on every valid output cycle.
module tb_ecc_dec_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = 32'h0;
    logic [1:0]  mod = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] data_out;
    logic [1:0]  num_of_errors;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int          checks = 0;
    int          errors = 0;
    logic [27:0] exp_q[$];
    bit          rst_seen = 1'b1;
    bit          bp_en = 1'b0;
    bit          stall_hold = 1'b0;
    int          cyc = 0;
    logic [31:0] infos [3] = '{32'h0000_0006, 32'h0000_05A3, 32'h02B4_C1D5};

    ecc_dec_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .mod           (mod),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_out      (data_out),
        .num_of_errors (num_of_errors),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    // Encoder from the construction rule: parity bit i (i < p-1) covers info bits whose
    // pattern has bit i set, info bit t uses the t-th smallest pattern of weight >= 2,
    // and bit p-1 makes the whole word even.
    function automatic logic [31:0] model_encode(input int m, input logic [31:0] info);
        int p;
        int k;
        int idx;
        logic [31:0] par;
        logic [31:0] w;
        logic [31:0] kmask;
        p = 4 + m;
        k = (8 << m) - p;
        idx = 0;
        par = 32'h0;
        kmask = (32'h1 << k) - 32'h1;
        for (int v = 1; v < (1 << (p - 1)); v++) begin
            if ($countones(v) >= 2) begin
                if (info[idx]) par = par ^ 32'(v);
                idx++;
            end
        end
        w = ((info & kmask) << p) | par;
        w[p-1] = ^w;
        return w;
    endfunction

    // Decoder by search: a word is a codeword iff re-encoding its info reproduces it.
    function automatic logic [27:0] model_decode(input int m, input logic [31:0] rx);
        int p;
        int n;
        logic [31:0] w;
        logic [31:0] c;
        logic [31:0] nmask;
        if (m == 3) return {2'd3, 26'd0};
        p = 4 + m;
        n = 8 << m;
        nmask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        w = rx & nmask;
        if (model_encode(m, w >> p) == w) return {2'd0, 26'(w >> p)};
        for (int j = 0; j < n; j++) begin
            c = w ^ (32'h1 << j);
            if (model_encode(m, c >> p) == c) return {2'd1, 26'(c >> p)};
        end
        return {2'd2, 26'(w >> p)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        cyc++;
        if (stall_hold) out_ready = 1'b0;
        else if (bp_en) out_ready = ((cyc % 3) != 0);
        else out_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rst_seen = 1'b1;
        end else begin
            if (rst_seen) begin
                check("post_reset_out_valid", 32'(out_valid), 32'h0);
                rst_seen = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid actual=data %h err %0d required=no output", data_out, num_of_errors);
                end else begin
                    check("data_out", 32'(data_out), 32'(exp_q[0][25:0]));
                    check("num_of_errors", 32'(num_of_errors), 32'(exp_q[0][27:26]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_decode(int'(mod), data_in));
        end
    end

    task automatic send(input logic [1:0] m, input logic [31:0] d);
        int waited;
        waited = 0;
        mod = m;
        data_in = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("send_accept", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cw;
        logic [31:0] junk;
        logic [27:0] r;
        int n;

        check("pin_enc8", model_encode(0, 32'hA), 32'h0000_00AA);
        check("pin_enc16", model_encode(1, 32'h1), 32'h0000_0033);
        check("pin_enc32", model_encode(2, 32'h1), 32'h0000_0063);
        r = model_decode(0, 32'hAA);
        check("pin_dec_clean", 32'(r), 32'({2'd0, 26'hA}));
        r = model_decode(0, 32'h8A);
        check("pin_dec_single", 32'(r), 32'({2'd1, 26'hA}));
        r = model_decode(0, 32'h8B);
        check("pin_dec_double", 32'(r), 32'({2'd2, 26'h8}));
        r = model_decode(3, 32'h0);
        check("pin_dec_illegal", 32'(r), 32'({2'd3, 26'h0}));

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_num_of_errors", 32'(num_of_errors), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        mod = 2'b00;
        data_in = 32'hAA;
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("lat_cycle2_out_valid", 32'(out_valid), 32'h1);
        @(posedge clk);
        #1;
        drain();

        send(2'b00, 32'h0000_008A);
        send(2'b00, 32'h0000_008B);
        send(2'b11, 32'h0000_0000);
        send(2'b01, model_encode(1, infos[1]));
        send(2'b10, model_encode(2, infos[2]) ^ 32'h0000_0080);
        send(2'b00, model_encode(0, 32'h5) ^ 32'h0000_0011);
        send(2'b11, 32'h1234_5678);
        send(2'b01, model_encode(1, 32'h7FF) ^ 32'h0000_0010);
        drain();

        for (int m = 0; m < 3; m++) begin
            bp_en = (m == 1);
            cw = model_encode(m, infos[m]);
            n = 8 << m;
            junk = (n == 32) ? 32'h0 : (32'hDEAD_BEEF & ~((32'h1 << n) - 32'h1));
            send(2'(m), cw | junk);
            for (int j = 0; j < n; j++) send(2'(m), (cw ^ (32'h1 << j)) | junk);
            for (int j = 0; j < n; j++) begin
                for (int l = j + 1; l < n; l++) begin
                    send(2'(m), (cw ^ (32'h1 << j) ^ (32'h1 << l)) | junk);
                end
            end
        end
        bp_en = 1'b0;
        drain();

        stall_hold = 1'b1;
        send(2'b00, model_encode(0, 32'h3));
        send(2'b01, model_encode(1, 32'h123) ^ 32'h0000_0400);
        mod = 2'b10;
        data_in = model_encode(2, 32'h0155_5555) ^ 32'h0000_0003;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        stall_hold = 1'b0;
        @(negedge clk);
        check("stall_release_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        send(2'b10, model_encode(2, 32'h00AB_CDEF));
        send(2'b10, model_encode(2, 32'h0012_3456) ^ 32'h0000_0100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'h0);
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale", 32'(out_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        send(2'b01, model_encode(1, 32'h2AA) ^ 32'h0000_8000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
